// File: rtl/swipt_pkg.sv
// Constants and types shared across the SWIPT data link. The transmitter
// uses the same chip encoding, so both ends agree on what a '1' looks like.
package swipt_pkg;

    localparam int ADC_W         = 12;
    localparam int HALF_BIT_CLKS = 64;

    // Chip pairs, first-transmitted chip in bit 1
    localparam logic [1:0] CHIP_ONE  = 2'b01;
    localparam logic [1:0] CHIP_ZERO = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        SAMPLE
    } state_t;

endpackage

// File: rtl/adc_slicer.sv
// Turns raw ADC samples into a binary chip stream against an exponential
// running mean with hysteresis, and flags chip transitions one cycle later.
module adc_slicer #(
    parameter int ADC_W     = swipt_pkg::ADC_W,
    parameter int AVG_SHIFT = 4,
    parameter int HYST      = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             data_rec,
    input  logic             preload,
    input  logic [ADC_W-1:0] adc,
    output logic             chip,
    output logic             rise,
    output logic             fall,
    output logic [ADC_W-1:0] mean
);

    localparam int ACC_W = ADC_W + AVG_SHIFT;

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_next;
    logic             chip_reg;
    logic             chip_d_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic [ADC_W:0]   adc_ext;
    logic [ADC_W:0]   mean_ext;
    logic             above;
    logic             below;

    assign mean     = acc_reg[ACC_W-1:AVG_SHIFT];
    assign acc_next = acc_reg - (acc_reg >> AVG_SHIFT) + ACC_W'(adc);

    // One extra bit so mean+HYST and adc+HYST never wrap
    assign adc_ext  = {1'b0, adc};
    assign mean_ext = {1'b0, mean};
    assign above    = adc_ext > (mean_ext + (ADC_W + 1)'(HYST));
    assign below    = (adc_ext + (ADC_W + 1)'(HYST)) < mean_ext;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            acc_reg    <= '0;
            chip_reg   <= 1'b0;
            chip_d_reg <= 1'b0;
            rise_reg   <= 1'b0;
            fall_reg   <= 1'b0;
        end else begin
            // A fresh burst starts from the reset chip level so a stale high
            // chip cannot swallow the leading rising edge.
            if (preload) begin
                acc_reg  <= {adc, {AVG_SHIFT{1'b0}}};
                chip_reg <= 1'b0;
            end else if (data_rec) begin
                acc_reg <= acc_next;
                if (above) begin
                    chip_reg <= 1'b1;
                end else if (below) begin
                    chip_reg <= 1'b0;
                end
            end
            chip_d_reg <= chip_reg;
            rise_reg   <= chip_reg & ~chip_d_reg;
            fall_reg   <= ~chip_reg & chip_d_reg;
        end
    end

    assign chip = chip_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/manchester_rx.sv
// Manchester bit recovery: locks on the mid-bit edge of a leading '1', then
// accepts only edges inside the mid-bit window and assembles MSB-first words.
module manchester_rx #(
    parameter int ADC_W         = swipt_pkg::ADC_W,
    parameter int HALF_BIT_CLKS = swipt_pkg::HALF_BIT_CLKS,
    parameter int WORD_BITS     = 16,
    parameter int AVG_SHIFT     = 4,
    parameter int HYST          = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 data_rec,
    input  logic [ADC_W-1:0]     ADC,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 word_err,
    output logic                 busy,
    output logic [ADC_W-1:0]     mean
);
    import swipt_pkg::*;

    localparam int CNT_MAX = 3 * HALF_BIT_CLKS;
    localparam int WIN_LO  = (3 * HALF_BIT_CLKS) / 2;
    localparam int WIN_HI  = (5 * HALF_BIT_CLKS) / 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(WORD_BITS + 1);

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BIT_W-1:0]     bitcnt_reg, bitcnt_next;
    logic [WORD_BITS-1:0] shift_reg, shift_next;
    logic [WORD_BITS-1:0] word_reg, word_next;
    logic                 valid_reg, valid_next;
    logic                 err_reg, err_next;
    logic                 preload;
    logic                 chip;
    logic                 rise;
    logic                 fall;
    logic                 in_window;
    logic [WORD_BITS-1:0] shifted;

    adc_slicer #(
        .ADC_W     (ADC_W),
        .AVG_SHIFT (AVG_SHIFT),
        .HYST      (HYST)
    ) u_slicer (
        .clk      (clk),
        .nrst     (nrst),
        .data_rec (data_rec),
        .preload  (preload),
        .adc      (ADC),
        .chip     (chip),
        .rise     (rise),
        .fall     (fall),
        .mean     (mean)
    );

    assign in_window = (cnt_reg >= CNT_W'(WIN_LO)) && (cnt_reg <= CNT_W'(WIN_HI));
    // The chip has already settled at its post-edge level: 1 after a rise, 0 after a fall
    assign shifted   = {shift_reg[WORD_BITS-2:0], chip};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bitcnt_reg <= '0;
            shift_reg  <= '0;
            word_reg   <= '0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bitcnt_reg <= bitcnt_next;
            shift_reg  <= shift_next;
            word_reg   <= word_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = (cnt_reg == CNT_W'(CNT_MAX)) ? cnt_reg : cnt_reg + CNT_W'(1);
        bitcnt_next = bitcnt_reg;
        shift_next  = shift_reg;
        word_next   = word_reg;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        preload     = 1'b0;
        if (!data_rec) begin
            state_next  = IDLE;
            cnt_next    = '0;
            bitcnt_next = '0;
            shift_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    preload    = 1'b1;
                    state_next = SEEK;
                end
                SEEK: begin
                    if (rise) begin
                        shift_next  = WORD_BITS'(1);
                        bitcnt_next = BIT_W'(1);
                        cnt_next    = '0;
                        state_next  = SAMPLE;
                    end
                end
                SAMPLE: begin
                    // An in-window edge beats a timeout raised on the same cycle
                    if ((rise || fall) && in_window) begin
                        cnt_next = '0;
                        if (bitcnt_reg == BIT_W'(WORD_BITS - 1)) begin
                            word_next   = shifted;
                            valid_next  = 1'b1;
                            shift_next  = '0;
                            bitcnt_next = '0;
                            state_next  = SEEK;
                        end else begin
                            shift_next  = shifted;
                            bitcnt_next = bitcnt_reg + BIT_W'(1);
                        end
                    end else if (cnt_reg > CNT_W'(WIN_HI)) begin
                        err_next    = 1'b1;
                        shift_next  = '0;
                        bitcnt_next = '0;
                        state_next  = SEEK;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign word       = word_reg;
    assign word_valid = valid_reg;
    assign word_err   = err_reg;
    assign busy       = (state_reg == SAMPLE);

endmodule

// File: tb/tb_manchester_rx.sv
// Directed bench for manchester_rx: table of whole-word vectors plus
// hand-written timeout, abort, reset and back-to-back sequences.
module tb_manchester_rx;
    import swipt_pkg::*;

    localparam logic [11:0] HI = 12'd3000;
    localparam logic [11:0] LO = 12'd1000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        data_rec = 1'b0;
    logic [11:0] ADC = LO;
    logic [15:0] word;
    logic        word_valid;
    logic        word_err;
    logic        busy;
    logic [11:0] mean;

    manchester_rx dut (
        .clk        (clk),
        .nrst       (nrst),
        .data_rec   (data_rec),
        .ADC        (ADC),
        .word       (word),
        .word_valid (word_valid),
        .word_err   (word_err),
        .busy       (busy),
        .mean       (mean)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] vq[$];
    int          vcyc[$];
    int          ecyc[$];
    int          busy_cnt = 0;
    int          both_hi = 0;
    int          first_mid = 0;
    int          last_mid = 0;

    always @(negedge clk) begin
        if (word_valid) begin
            vq.push_back(word);
            vcyc.push_back(cyc);
        end
        if (word_err) ecyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (word_valid && word_err) both_hi++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] data;
        int          len;
        bit          noise;
        logic [15:0] exp_word;
        int          exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_chip(input logic lvl, input int len, input bit noise);
        for (int k = 0; k < len; k++) begin
            if (noise && lvl && k >= 17 && k < 47)
                ADC = (k % 2 == 1) ? mean + 12'd20 : mean - 12'd20;
            else
                ADC = lvl ? HI : LO;
            @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input int len, input bit noise);
        logic [1:0] pair;
        pair = b ? CHIP_ONE : CHIP_ZERO;
        send_chip(pair[1], len, noise);
        last_mid = cyc;
        send_chip(pair[0], len, noise);
    endtask

    task automatic send_word(input logic [15:0] w, input int len, input bit noise, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[15 - i], len, noise);
            if (i == 0) first_mid = last_mid;
        end
    endtask

    task automatic clear_log();
        vq.delete();
        vcyc.delete();
        ecyc.delete();
        busy_cnt = 0;
    endtask

    initial begin
        int m;

        vecs[0] = '{16'hF065, 64, 1'b0, 16'hF065, 1920};
        vecs[1] = '{16'hF065, 76, 1'b0, 16'hF065, 2280};
        vecs[2] = '{16'hF065, 55, 1'b0, 16'hF065, 1650};
        vecs[3] = '{16'hF065, 64, 1'b1, 16'hF065, 1920};
        vecs[4] = '{16'hAAAB, 64, 1'b0, 16'hAAAB, 1920};
        vecs[5] = '{16'h8001, 60, 1'b0, 16'h8001, 1800};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_word", word, 0);
        check("reset_valid", word_valid, 0);
        check("reset_err", word_err, 0);
        check("reset_busy", busy, 0);
        check("reset_mean", mean, 0);
        nrst = 1'b1;
        @(negedge clk);

        // Whole-word vectors
        for (int i = 0; i < 6; i++) begin
            clear_log();
            data_rec = 1'b1;
            ADC = LO;
            send_word(vecs[i].data, vecs[i].len, vecs[i].noise, 16);
            repeat (4) @(negedge clk);
            data_rec = 1'b0;
            repeat (3) @(negedge clk);
            $display("vector %0d: data %h chip_len %0d noise %0d", i, vecs[i].data, vecs[i].len, vecs[i].noise);
            check("vec_valid_count", vq.size(), 1);
            check("vec_word", (vq.size() > 0) ? int'(vq[0]) : -1, vecs[i].exp_word);
            check("vec_latency", (vcyc.size() > 0) ? vcyc[0] - last_mid : -1, 3);
            check("vec_err_count", ecyc.size(), 0);
            check("vec_busy_cycles", busy_cnt, vecs[i].exp_busy);
            check("vec_word_hold", word, vecs[i].exp_word);
        end

        // Timeout after 5 bits, then resync on a fresh word
        clear_log();
        data_rec = 1'b1;
        ADC = LO;
        send_word(16'hF065, 64, 1'b0, 5);
        m = last_mid;
        for (int k = 0; k < 200; k++) begin
            ADC = HI;
            @(negedge clk);
        end
        $display("timeout: 5 bits then 200 clks high");
        check("to_err_count", ecyc.size(), 1);
        check("to_err_offset", (ecyc.size() > 0) ? ecyc[0] - m : -1, 165);
        check("to_no_valid", vq.size(), 0);
        check("to_word_unchanged", word, 16'h8001);
        send_word(16'hAAAB, 64, 1'b0, 16);
        repeat (4) @(negedge clk);
        data_rec = 1'b0;
        repeat (3) @(negedge clk);
        check("to_resync_count", vq.size(), 1);
        check("to_resync_word", (vq.size() > 0) ? int'(vq[0]) : -1, 16'hAAAB);
        check("to_err_total", ecyc.size(), 1);

        // data_rec drop after 8 bits
        clear_log();
        data_rec = 1'b1;
        ADC = LO;
        send_word(16'hF065, 64, 1'b0, 8);
        $display("abort: data_rec dropped after 8 bits");
        check("ab_busy_before", busy, 1);
        m = mean;
        data_rec = 1'b0;
        ADC = HI;
        @(negedge clk);
        check("ab_idle_next", busy, 0);
        for (int k = 0; k < 10; k++) begin
            ADC = (k % 2 == 1) ? HI : LO;
            @(negedge clk);
        end
        check("ab_mean_frozen", mean, m);
        check("ab_no_valid", vq.size(), 0);
        check("ab_no_err", ecyc.size(), 0);
        check("ab_word_hold", word, 16'hAAAB);

        // One-cycle reset mid-word
        clear_log();
        data_rec = 1'b1;
        ADC = LO;
        send_word(16'hF065, 64, 1'b0, 8);
        $display("reset: nrst low for one clk mid-word");
        nrst = 1'b0;
        @(negedge clk);
        check("rst_word", word, 0);
        check("rst_valid", word_valid, 0);
        check("rst_err", word_err, 0);
        check("rst_busy", busy, 0);
        check("rst_mean", mean, 0);
        nrst = 1'b1;
        data_rec = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back words, no gap
        clear_log();
        data_rec = 1'b1;
        ADC = LO;
        send_word(16'hF065, 64, 1'b0, 16);
        send_word(16'h8001, 64, 1'b0, 16);
        repeat (4) @(negedge clk);
        data_rec = 1'b0;
        repeat (3) @(negedge clk);
        $display("back-to-back: F065 then 8001");
        check("b2b_count", vq.size(), 2);
        check("b2b_word0", (vq.size() > 0) ? int'(vq[0]) : -1, 16'hF065);
        check("b2b_word1", (vq.size() > 1) ? int'(vq[1]) : -1, 16'h8001);
        check("b2b_spacing", (vcyc.size() > 1) ? vcyc[1] - vcyc[0] : -1, 2048);
        check("b2b_err", ecyc.size(), 0);

        check("valid_err_exclusive", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_rx.md
Name: manchester_rx

Overview:
- Receive-side bit recovery for the SWIPT data link.
- Sits directly downstream of the analog network's 12-bit ADC output. Runs in parallel with the read-data/mean-current blocks.
- Slices ADC samples into chips against a running mean and decodes Manchester chips (1 = chips 0,1; 0 = chips 1,0).
- Emits WORD_BITS-wide words with a valid pulse while data_rec is high.

Parameters:
- ADC_W, 12, ADC sample width.
- HALF_BIT_CLKS, 64, clk cycles per chip (half bit). Must be even and ≥ 8.
- WORD_BITS, 16, bits per received word.
- AVG_SHIFT, 4, running-mean filter exponent (alpha = 2^-AVG_SHIFT).
- HYST, 32, slicer hysteresis in ADC LSBs.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous active-low reset.
- data_rec  in  1  receive enable; level.
- ADC  in  ADC_W  raw ADC sample, one per clk.
- word  out  WORD_BITS  last decoded word; first-received bit in MSB.
- word_valid  out  1  one-cycle pulse, word updated this cycle.
- word_err  out  1  one-cycle pulse, word aborted on timing violation.
- busy  out  1  high in SAMPLE state.
- mean  out  ADC_W  current slicer threshold (debug/observability).

Behaviour:
- Clock and reset:
  - One clock, clk. Reset nrst is synchronous, active-low, sampled on the rising clk edge.
  - Reset values: word=0, word_valid=0, word_err=0, busy=0, mean=0, accumulator=0, chip=0, state=IDLE.
- Slicer:
  - Accumulator acc is ADC_W+AVG_SHIFT bits, unsigned: acc <= acc - (acc>>AVG_SHIFT) + ADC each cycle when data_rec=1. mean = acc>>AVG_SHIFT.
  - On the cycle data_rec rises from IDLE, preload acc <= ADC<<AVG_SHIFT.
  - chip <= 1 if ADC > mean+HYST; chip <= 0 if ADC+HYST < mean; otherwise chip holds. Compare at ADC_W+1 bits, no wrap.
  - Edge = chip != chip_d (chip_d is a 1-cycle register). Rising edge = chip_d=0, chip=1.
- Counter: cnt counts clk cycles since the last accepted edge and saturates at 3*HALF_BIT_CLKS.
- States:
  - IDLE: outputs idle. data_rec=1 -> SEEK.
  - SEEK: wait for a rising edge. This is the mid-bit edge of the mandatory leading '1'. On it: shift in 1, bitcnt=1, cnt=0 -> SAMPLE. Falling edges are ignored.
  - SAMPLE, edge with cnt < 3H/2 (H = HALF_BIT_CLKS): bit-boundary edge, ignored.
  - SAMPLE, edge with 3H/2 ≤ cnt ≤ 5H/2: accepted. Shift in 1 if rising, 0 if falling; bitcnt++; cnt=0.
  - SAMPLE, cnt > 5H/2 with no accepted edge: word_err pulse next cycle, shift register cleared -> SEEK.
  - SAMPLE, bitcnt reaches WORD_BITS on an accepted edge: next cycle word <= shift register, word_valid=1 for one cycle -> SEEK.
- Latency: word_valid asserts exactly 3 cycles after the ADC sample whose threshold crossing forms the final mid-bit edge (chip register, edge register, output register).
- data_rec falling in any state:
  - Go to IDLE next cycle. Partial word discarded. No valid or err pulse. word holds its last value.
  - acc freezes; it is not cleared.
- Simultaneous events:
  - Timeout and edge on the same cycle: the edge wins if cnt ≤ 5H/2.
  - word_valid and word_err are never both high.
- nrst=0 overrides everything, including a pending valid pulse.

Decomposition:
- Shared package swipt_pkg holds: ADC_W, state enum (IDLE, SEEK, SAMPLE), the default HALF_BIT_CLKS, and the chip-encoding constants (CHIP_ONE=2'b01, CHIP_ZERO=2'b10). The same constants are used by the data-stream transmitter.
- One sub-module, adc_slicer, owns the accumulator, mean, hysteresis comparator and chip/edge registers. Outputs: chip, rise, fall, mean.
- The FSM, counter and shifter stay in manchester_rx.

Test Plan:
- Basic decode:
  - Stimulus: data_rec=1, ADC driven 3000/1000 chips of 64 clks carrying 1111000001100101.
  - Required: one word_valid, word=16'hF065, word_err=0, busy high from the first rising edge until valid.
- Timing tolerance:
  - Stimulus: same word with every chip stretched to 76 clks (bit period 152 ≤ 160).
  - Required: word=16'hF065. Repeat with 55-clk chips (110 ≥ 96): same result.
- Timeout:
  - Stimulus: after 5 valid bits, hold ADC at 3000 for 200 clks.
  - Required: word_err pulses exactly once after cnt exceeds 160. word unchanged. FSM resyncs and decodes the next 16'hAAAB correctly.
- Hysteresis:
  - Stimulus: a ±20 LSB noise burst around mean for 30 clks mid-chip.
  - Required: no chip toggle, decode still 16'hF065.
- Abort:
  - Stimulus: drop data_rec after 8 bits.
  - Required: IDLE next cycle, no valid/err pulse, word retains the previous value.
  - Stimulus: pull nrst=0 for 1 clk mid-word.
  - Required: all outputs 0 on the next cycle.
- Back-to-back:
  - Stimulus: two words 16'hF065 and 16'h8001 with no gap.
  - Required: two valid pulses 32*64 clks apart, values in order.
